// File: rtl/peak_readout_if.sv
// Output stream bundle for peak_readout: tagged peak words toward the readout path.
interface peak_readout_if #(
  parameter int unsigned DW = 12
);
  logic [DW+3:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/peak_readout.sv
// Snapshots four channel peaks per done pulse into a small frame buffer and
// drains each frame as four tagged words; frames arriving while full are dropped.
module peak_readout #(
  parameter int unsigned DW     = 12,
  parameter int unsigned FRAMES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          done,
  input  logic [DW-1:0] in_1,
  input  logic [DW-1:0] in_2,
  input  logic [DW-1:0] in_3,
  input  logic [DW-1:0] in_4,
  peak_readout_if.master m,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic [7:0]    frame_cnt
);

  localparam int unsigned PW = $clog2(FRAMES);
  localparam int unsigned FW = $clog2(FRAMES + 1);
  localparam logic [FW-1:0] FULL = FW'(FRAMES);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      beat_q, beat_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]   fill_q, fill_d;
  logic [1:0]      seq_ctr_q, seq_ctr_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic [DW-1:0]   val_q [FRAMES][4];
  logic [1:0]      seq_q [FRAMES];

  logic hs;
  logic last_hs;
  logic cap;
  logic drop;

  always_comb begin
    hs      = (state_q == SEND) && m.m_ready;
    last_hs = hs && (beat_q == 2'd3);
    // A last-beat handshake frees its slot in the same cycle, so a full buffer can still accept.
    cap     = done && ((fill_q != FULL) || last_hs);
    drop    = done && !cap;
  end

  always_comb begin
    fill_d      = fill_q;
    beat_d      = beat_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    seq_ctr_d   = seq_ctr_q;
    frame_cnt_d = frame_cnt_q;
    state_d     = state_q;

    case ({cap, last_hs})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase

    if (cap) begin
      wr_ptr_d  = wr_ptr_q + PW'(1);
      seq_ctr_d = seq_ctr_q + 2'd1;
    end

    if (last_hs) begin
      beat_d      = 2'd0;
      rd_ptr_d    = rd_ptr_q + PW'(1);
      frame_cnt_d = frame_cnt_q + 8'd1;
    end else if (hs) begin
      beat_d = beat_q + 2'd1;
    end

    case (state_q)
      IDLE: if (fill_d != '0) state_d = SEND;
      SEND: if (fill_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ovf_d = drop || (ovf_q && !ovf_clr);
  end

  always_comb begin
    m.m_valid = 1'b0;
    m.m_last  = 1'b0;
    m.m_data  = '0;
    if (state_q == SEND) begin
      m.m_valid = 1'b1;
      m.m_last  = (beat_q == 2'd3);
      m.m_data  = {beat_q, seq_q[rd_ptr_q], val_q[rd_ptr_q][beat_q]};
    end
  end

  assign ovf       = ovf_q;
  assign frame_cnt = frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      seq_ctr_q   <= '0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
      for (int unsigned f = 0; f < FRAMES; f++) begin
        seq_q[f] <= '0;
        for (int unsigned c = 0; c < 4; c++) begin
          val_q[f][c] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      seq_ctr_q   <= seq_ctr_d;
      ovf_q       <= ovf_d;
      frame_cnt_q <= frame_cnt_d;
      if (cap) begin
        val_q[wr_ptr_q][0] <= in_1;
        val_q[wr_ptr_q][1] <= in_2;
        val_q[wr_ptr_q][2] <= in_3;
        val_q[wr_ptr_q][3] <= in_4;
        seq_q[wr_ptr_q]    <= seq_ctr_q;
      end
    end
  end

endmodule
